// File: rtl/uart_mc_reg_if.sv
// Multi-channel UART register bank behind one memory-mapped slave port.
// Define UART_MC_REG_IF_PEEK_EN to add the non-popping RX_PEEK register at 0x24.
module uart_mc_reg_if #(
   parameter int          NUM_CH       = 4,
   parameter int          ADDR_WIDTH   = 8,
   parameter int          DATA_WIDTH   = 32,
   parameter int          CNT_WIDTH    = 8,
   parameter int          FIFO_DEPTH   = 64,
   parameter int          NEAR_FULL_TH = 48,
   parameter logic [31:0] CLK_DIV_RST  = 32'h28B1
) (
   input  logic                        clk_i,
   input  logic                        srst_i,
   input  logic                        mem_we_i,
   input  logic [ADDR_WIDTH-1:0]       mem_waddr_i,
   input  logic [DATA_WIDTH-1:0]       mem_wdata_i,
   input  logic [3:0]                  mem_wstrb_i,
   output logic                        mem_wvalid_o,
   output logic [1:0]                  mem_wresp_o,
   input  logic                        mem_re_i,
   input  logic [ADDR_WIDTH-1:0]       mem_raddr_i,
   output logic                        mem_rvalid_o,
   output logic [DATA_WIDTH-1:0]       mem_rdata_o,
   output logic [1:0]                  mem_rresp_o,
   output logic [NUM_CH-1:0]           ctrl_clk_en_o,
   output logic [NUM_CH-1:0]           tx_fifo_flush_o,
   output logic [NUM_CH-1:0]           rx_fifo_flush_o,
   output logic [NUM_CH*3-1:0]         cfg_o,
   output logic [NUM_CH*32-1:0]        clk_div_o,
   input  logic [NUM_CH*CNT_WIDTH-1:0] tx_fifo_count_i,
   input  logic [NUM_CH*CNT_WIDTH-1:0] rx_fifo_count_i,
   output logic [NUM_CH*8-1:0]         tx_fifo_data_o,
   output logic [NUM_CH-1:0]           tx_fifo_data_valid_o,
   input  logic [NUM_CH-1:0]           tx_fifo_data_ready_i,
   input  logic [NUM_CH*8-1:0]         rx_fifo_data_i,
   input  logic [NUM_CH-1:0]           rx_fifo_data_valid_i,
   output logic [NUM_CH-1:0]           rx_fifo_data_ready_o,
   input  logic [NUM_CH-1:0]           rx_parity_err_i,
   output logic [NUM_CH-1:0]           irq_o
);

   localparam int          CHW = ADDR_WIDTH - 6;
   localparam int          CW  = CNT_WIDTH;
   localparam logic [31:0] FD  = FIFO_DEPTH;
   localparam logic [31:0] NFT = NEAR_FULL_TH;

   localparam logic [5:0] OFF_CTRL = 6'h00;
   localparam logic [5:0] OFF_CFG  = 6'h04;
   localparam logic [5:0] OFF_DIV  = 6'h08;
   localparam logic [5:0] OFF_TXS  = 6'h0C;
   localparam logic [5:0] OFF_RXS  = 6'h10;
   localparam logic [5:0] OFF_RXD  = 6'h18;
   localparam logic [5:0] OFF_TXD  = 6'h14;
   localparam logic [5:0] OFF_IEN  = 6'h1C;
   localparam logic [5:0] OFF_IST  = 6'h20;
`ifdef UART_MC_REG_IF_PEEK_EN
   localparam logic [5:0] OFF_PEEK = 6'h24;
`endif

   logic [CHW-1:0]    wch, rch;
   logic [5:0]        woff, roff;
   logic [NUM_CH-1:0] wsel, rsel;
   logic              w_hit, r_hit;

   logic              clk_en_q [NUM_CH];
   logic [2:0]        cfg_q    [NUM_CH];
   logic [31:0]       div_q    [NUM_CH];
   logic [5:0]        ien_q    [NUM_CH];
   logic [5:0]        stat_q   [NUM_CH];
   logic [5:0]        stat_d   [NUM_CH];
   logic [4:0]        cond_q   [NUM_CH];
   logic [4:0]        cond     [NUM_CH];
   logic [NUM_CH-1:0] txf_q, rxf_q;

   logic              wvalid_q, rvalid_q;
   logic [1:0]        wresp_q, rresp_q;
   logic [31:0]       rdata_q;

   logic [CW-1:0]     w_tcnt, w_rcnt, r_tcnt, r_rcnt;
   logic              w_trdy, r_trdy, r_rvld, r_clk_en;
   logic [7:0]        r_rdat;
   logic [2:0]        r_cfg;
   logic [31:0]       r_div;
   logic [5:0]        r_ien, r_stat;

   logic              wok, w_idle, w_any;
   logic              wr_ctrl, wr_cfg, wr_div, wr_tx, wr_ien, wr_clr;
   logic              rok, rd_pop;
   logic [31:0]       rdat;

   assign wch  = mem_waddr_i[ADDR_WIDTH-1:6];
   assign woff = mem_waddr_i[5:0];
   assign rch  = mem_raddr_i[ADDR_WIDTH-1:6];
   assign roff = mem_raddr_i[5:0];

   // Per-channel selects double as the out-of-range channel check.
   always_comb begin
      wsel = '0;
      rsel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         wsel[c] = (wch == CHW'(c));
         rsel[c] = (rch == CHW'(c));
      end
   end
   assign w_hit = |wsel;
   assign r_hit = |rsel;

   always_comb begin
      w_tcnt = '0; w_rcnt = '0; w_trdy = 1'b0;
      r_tcnt = '0; r_rcnt = '0; r_trdy = 1'b0;
      r_rvld = 1'b0; r_rdat = '0; r_clk_en = 1'b0;
      r_cfg = '0; r_div = '0; r_ien = '0; r_stat = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wsel[c]) begin
            w_tcnt = tx_fifo_count_i[c*CW +: CW];
            w_rcnt = rx_fifo_count_i[c*CW +: CW];
            w_trdy = tx_fifo_data_ready_i[c];
         end
         if (rsel[c]) begin
            r_tcnt   = tx_fifo_count_i[c*CW +: CW];
            r_rcnt   = rx_fifo_count_i[c*CW +: CW];
            r_trdy   = tx_fifo_data_ready_i[c];
            r_rvld   = rx_fifo_data_valid_i[c];
            r_rdat   = rx_fifo_data_i[c*8 +: 8];
            r_clk_en = clk_en_q[c];
            r_cfg    = cfg_q[c];
            r_div    = div_q[c];
            r_ien    = ien_q[c];
            r_stat   = stat_q[c];
         end
      end
   end

   always_comb begin
      wok = 1'b0; wr_ctrl = 1'b0; wr_cfg = 1'b0; wr_div = 1'b0;
      wr_tx = 1'b0; wr_ien = 1'b0; wr_clr = 1'b0;
      w_idle = (w_tcnt == '0) && (w_rcnt == '0);
      w_any  = |mem_wstrb_i;
      if (mem_we_i && w_hit && !srst_i) begin
         unique case (1'b1)
            woff == OFF_CTRL: begin wok = 1'b1; wr_ctrl = mem_wstrb_i[0]; end
            woff == OFF_CFG:  begin
               wok    = w_idle || !w_any;
               wr_cfg = w_idle && mem_wstrb_i[0];
            end
            woff == OFF_DIV:  begin wok = w_idle || !w_any; wr_div = w_idle; end
            woff == OFF_TXD:  begin
               wok   = mem_wstrb_i[0] && w_trdy;
               wr_tx = wok;
            end
            woff == OFF_IEN:  begin wok = 1'b1; wr_ien = mem_wstrb_i[0]; end
            woff == OFF_IST:  begin wok = 1'b1; wr_clr = mem_wstrb_i[0]; end
            default:          wok = 1'b0;
         endcase
      end
   end

   always_comb begin
      rok = 1'b0; rd_pop = 1'b0; rdat = '0;
      if (mem_re_i && r_hit && !srst_i) begin
         unique case (1'b1)
            roff == OFF_CTRL: begin rok = 1'b1; rdat = {31'd0, r_clk_en}; end
            roff == OFF_CFG:  begin rok = 1'b1; rdat = {29'd0, r_cfg}; end
            roff == OFF_DIV:  begin rok = 1'b1; rdat = r_div; end
            roff == OFF_TXS:  begin
               rok = 1'b1; rdat = 32'(r_tcnt); rdat[31] = r_trdy;
            end
            roff == OFF_RXS:  begin
               rok = 1'b1; rdat = 32'(r_rcnt); rdat[31] = r_rvld;
            end
            roff == OFF_RXD:  begin
               rok = r_rvld; rd_pop = r_rvld; rdat = {24'd0, r_rdat};
            end
            roff == OFF_IEN:  begin rok = 1'b1; rdat = {26'd0, r_ien}; end
            roff == OFF_IST:  begin rok = 1'b1; rdat = {26'd0, r_stat}; end
`ifdef UART_MC_REG_IF_PEEK_EN
            roff == OFF_PEEK: begin rok = r_rvld; rdat = {24'd0, r_rdat}; end
`endif
            default:          rok = 1'b0;
         endcase
      end
   end

   // Status bits [5:1] fire on rising edges of these levels; bit 0 is the parity event.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cond[c] = {32'(tx_fifo_count_i[c*CW +: CW]) == FD,
                    32'(tx_fifo_count_i[c*CW +: CW]) >= NFT,
                    32'(rx_fifo_count_i[c*CW +: CW]) == FD,
                    32'(rx_fifo_count_i[c*CW +: CW]) >= NFT,
                    rx_fifo_data_valid_i[c]};
         stat_d[c] = (stat_q[c] & ~((wr_clr && wsel[c]) ? mem_wdata_i[5:0] : 6'd0))
                   | {cond[c] & ~cond_q[c], rx_parity_err_i[c]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            clk_en_q[c] <= 1'b0;
            cfg_q[c]    <= '0;
            div_q[c]    <= CLK_DIV_RST;
            ien_q[c]    <= '0;
            stat_q[c]   <= '0;
            cond_q[c]   <= '0;
         end
         txf_q    <= '0;
         rxf_q    <= '0;
         wvalid_q <= 1'b0;
         wresp_q  <= 2'b00;
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cond_q[c] <= cond[c];
            stat_q[c] <= stat_d[c];
            txf_q[c]  <= wr_ctrl && wsel[c] && mem_wdata_i[1];
            rxf_q[c]  <= wr_ctrl && wsel[c] && mem_wdata_i[2];
            if (wr_ctrl && wsel[c]) clk_en_q[c] <= mem_wdata_i[0];
            if (wr_cfg && wsel[c]) cfg_q[c] <= mem_wdata_i[2:0];
            if (wr_ien && wsel[c]) ien_q[c] <= mem_wdata_i[5:0];
            for (int b = 0; b < 4; b++)
               if (wr_div && wsel[c] && mem_wstrb_i[b])
                  div_q[c][8*b +: 8] <= mem_wdata_i[8*b +: 8];
         end
         wvalid_q <= mem_we_i;
         wresp_q  <= (mem_we_i && !wok) ? 2'b10 : 2'b00;
         rvalid_q <= mem_re_i;
         rresp_q  <= (mem_re_i && !rok) ? 2'b10 : 2'b00;
         rdata_q  <= rok ? rdat : 32'd0;
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ctrl_clk_en_o[c]          = clk_en_q[c];
         cfg_o[c*3 +: 3]           = cfg_q[c];
         clk_div_o[c*32 +: 32]     = div_q[c];
         irq_o[c]                  = |(stat_q[c] & ien_q[c]);
         tx_fifo_data_valid_o[c]   = wr_tx && wsel[c];
         tx_fifo_data_o[c*8 +: 8]  = (wr_tx && wsel[c]) ? mem_wdata_i[7:0] : 8'd0;
         rx_fifo_data_ready_o[c]   = rd_pop && rsel[c];
      end
   end

   assign tx_fifo_flush_o = txf_q;
   assign rx_fifo_flush_o = rxf_q;
   assign mem_wvalid_o    = wvalid_q;
   assign mem_wresp_o     = wresp_q;
   assign mem_rvalid_o    = rvalid_q;
   assign mem_rresp_o     = rresp_q;
   assign mem_rdata_o     = rdata_q;

endmodule

// File: tb/tb_uart_mc_reg_if.sv
// Directed bench for uart_mc_reg_if; 9-bit addresses so channel 4 (0x100) is reachable.
module tb_uart_mc_reg_if;

   localparam int NC = 4;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          srst;
   logic          we, re;
   logic [AW-1:0] waddr, raddr;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid, rvalid;
   logic [1:0]    wresp, rresp;
   logic [31:0]   rdata;
   logic [NC-1:0] clk_en, txfl, rxfl, txv, txr, rxv, rxr, perr, irq;
   logic [11:0]   cfg;
   logic [127:0]  cdiv;
   logic [31:0]   tcnt, rcnt, txd, rxd;

   logic [NC-1:0] txv_obs, rxr_obs;
   int            nvec = 0;
   int            nerr = 0;

   always #5 clk = ~clk;

   uart_mc_reg_if #(.NUM_CH(NC), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .srst_i(srst),
      .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
      .mem_wstrb_i(wstrb), .mem_wvalid_o(wvalid), .mem_wresp_o(wresp),
      .mem_re_i(re), .mem_raddr_i(raddr), .mem_rvalid_o(rvalid),
      .mem_rdata_o(rdata), .mem_rresp_o(rresp),
      .ctrl_clk_en_o(clk_en), .tx_fifo_flush_o(txfl), .rx_fifo_flush_o(rxfl),
      .cfg_o(cfg), .clk_div_o(cdiv),
      .tx_fifo_count_i(tcnt), .rx_fifo_count_i(rcnt),
      .tx_fifo_data_o(txd), .tx_fifo_data_valid_o(txv),
      .tx_fifo_data_ready_i(txr), .rx_fifo_data_i(rxd),
      .rx_fifo_data_valid_i(rxv), .rx_fifo_data_ready_o(rxr),
      .rx_parity_err_i(perr), .irq_o(irq)
   );

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d; wstrb = s;
      #1 txv_obs = txv;
      @(posedge clk);
      #1 we = 1'b0; wstrb = 4'h0; perr = '0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      @(negedge clk);
      re = 1'b1; raddr = a;
      #1 rxr_obs = rxr;
      @(posedge clk);
      #1 re = 1'b0;
   endtask

   initial begin
      srst = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; raddr = '0;
      wdata = '0; wstrb = '0; tcnt = '0; rcnt = '0; txr = '1;
      rxv = '0; rxd = '0; perr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_irq", irq, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_clkdiv", cdiv, {4{32'h28B1}});
      check("rst_clken", clk_en, 0);
      check("rst_cfg", cfg, 0);
      srst = 1'b0;

      rd(9'h008);
      check("div_rvalid", rvalid, 1);
      check("div_rdata", rdata, 32'h28B1);
      check("div_rresp", rresp, 0);
      check("div_irq", irq, 0);
      @(posedge clk); #1;
      check("rvalid_drop", rvalid, 0);

      wr(9'h080, 32'h6, 4'hF);
      check("flush_wvalid", wvalid, 1);
      check("flush_wresp", wresp, 0);
      check("txflush_on", txfl, 4'b0100);
      check("rxflush_on", rxfl, 4'b0100);
      @(posedge clk); #1;
      check("txflush_off", txfl, 0);
      check("rxflush_off", rxfl, 0);
      rd(9'h080);
      check("ctrl_rd0", rdata, 0);
      wr(9'h080, 32'h1, 4'h1);
      check("clken_out", clk_en, 4'b0100);
      rd(9'h080);
      check("ctrl_rd1", rdata, 1);

      tcnt = 32'h0000_0300;
      wr(9'h044, 32'h7, 4'hF);
      check("cfg_busy_resp", wresp, 2'b10);
      check("cfg_busy_val", cfg, 0);
      tcnt = '0;
      wr(9'h048, 32'h1234_5678, 4'h3);
      check("div_strb_resp", wresp, 0);
      check("div_strb_val", cdiv[63:32], 32'h0000_5678);
      wr(9'h044, 32'h7, 4'hF);
      check("cfg_ok", cfg, 12'h038);

      rxv = 4'b0001; rxd = 32'hA5;
      rd(9'h018);
      check("pop_ready", rxr_obs, 4'b0001);
      check("pop_rdata", rdata, 32'hA5);
      check("pop_rresp", rresp, 0);
      rxv = '0;
      rd(9'h018);
      check("nopop_ready", rxr_obs, 0);
      check("nopop_rresp", rresp, 2'b10);
      check("nopop_rdata", rdata, 0);
      rd(9'h020);
      check("ch0_stat", rdata, 32'h2);

      wr(9'h014, 32'h3C, 4'h1);
      check("txpush_v", txv_obs, 4'b0001);
      check("txpush_resp", wresp, 0);
      txr = 4'b1110;
      wr(9'h014, 32'h3C, 4'h1);
      check("txfull_v", txv_obs, 0);
      check("txfull_resp", wresp, 2'b10);
      txr = '1;
      wr(9'h00C, 32'h1, 4'hF);
      check("ro_wresp", wresp, 2'b10);

      rcnt = 32'h2F00_0000;
      wr(9'h0DC, 32'h4, 4'h1);
      @(negedge clk);
      rcnt = 32'h3000_0000;
      @(posedge clk); #1;
      check("nf_irq", irq, 4'b1000);
      rd(9'h0E0);
      check("nf_stat", rdata, 32'h4);
      @(negedge clk);
      perr = 4'b1000;
      wr(9'h0E0, 32'h4, 4'h1);
      check("w1c_irq", irq, 0);
      rd(9'h0E0);
      check("w1c_stat", rdata, 32'h1);
      perr = 4'b1000;
      wr(9'h0E0, 32'h1, 4'h1);
      rd(9'h0E0);
      check("set_wins", rdata, 32'h1);
      wr(9'h0E0, 32'h1, 4'h1);
      rd(9'h0E0);
      check("w1c_clear", rdata, 0);

      rd(9'h100);
      check("oor_rresp", rresp, 2'b10);
      check("oor_rdata", rdata, 0);
      wr(9'h100, 32'h1, 4'hF);
      check("oor_wresp", wresp, 2'b10);
      check("oor_noside", clk_en, 4'b0100);
      rxv = 4'b0001; rxd = 32'h5A;
      rd(9'h024);
      check("peek_nopop", rxr_obs, 0);
`ifdef UART_MC_REG_IF_PEEK_EN
      check("peek_rresp", rresp, 0);
      check("peek_rdata", rdata, 32'h5A);
`else
      check("peek_rresp", rresp, 2'b10);
      check("peek_rdata", rdata, 0);
`endif
      rxv = '0;

      @(negedge clk);
      we = 1'b1; waddr = 9'h048; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
      re = 1'b1; raddr = 9'h048;
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0; wstrb = '0;
      check("rw_pre", rdata, 32'h0000_5678);
      check("rw_wresp", wresp, 0);
      rd(9'h048);
      check("rw_post", rdata, 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
